rng_share_ctrl: RTL

//  Controller that sequences one free-running LFSR random generator and shares its output among
//  N_REQ sampling units (neuron sigmoid comparators) of the RBM datapath. Drives the generator's

---
 rtl/rng_share_if.sv | 26 ++
 rtl/rng_share_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rng_share_if.sv
// Signal bundle between the RNG share controller, its LFSR generator and the sampling units.
// The controller attaches through the slave modport; the environment drives the master side.
interface rng_share_if #(
  parameter int BITLENGTH = 8,
  parameter int N_REQ     = 4
);
  logic                 seed_load;
  logic [BITLENGTH-1:0] seed_in;
  logic [BITLENGTH-1:0] rng_data;
  logic                 gen_reset;
  logic [BITLENGTH-1:0] gen_seed;
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     gnt;
  logic [BITLENGTH-1:0] rand_out;
  logic                 ready;

  modport master (
    output seed_load, seed_in, rng_data, req,
    input  gen_reset, gen_seed, gnt, rand_out, ready
  );

  modport slave (
    input  seed_load, seed_in, rng_data, req,
    output gen_reset, gen_seed, gnt, rand_out, ready
  );
endinterface

// File: rtl/rng_share_ctrl.sv
// Sequences a shared LFSR (seed, warm-up discard) and hands one generator word per cycle
// to N_REQ sampling units through a registered round-robin arbiter.
module rng_share_ctrl #(
  parameter int                   BITLENGTH    = 8,
  parameter int                   N_REQ        = 4,
  parameter int                   WARMUP       = 8,
  parameter logic [BITLENGTH-1:0] SEED_DEFAULT = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  rng_share_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_WARM  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        warm_cnt_r, warm_cnt_s;
  logic [PW-1:0]        rr_ptr_r, rr_ptr_s;
  logic                 gen_reset_r, gen_reset_s;
  logic [BITLENGTH-1:0] gen_seed_r, gen_seed_s;
  logic [N_REQ-1:0]     gnt_r, gnt_s;
  logic [BITLENGTH-1:0] rand_r, rand_s;
  logic                 ready_r, ready_s;
  logic [PW:0]          pick_s;

  // MSB flags a winner; scanning offsets downward lets the lowest offset from ptr win.
  function automatic logic [PW:0] pick_winner(input logic [N_REQ-1:0] elig,
                                               input logic [PW-1:0]    ptr);
    logic [PW:0] result;
    int          idx;
    result = {(PW+1){1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (elig[PW'(idx)]) begin
        result = {1'b1, PW'(idx)};
      end
    end
    return result;
  endfunction

  // A unit granted this cycle is masked so no unit gets two words back to back.
  assign pick_s = pick_winner(bus.req & ~gnt_r, rr_ptr_r);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_SEED;
      warm_cnt_r  <= {CW{1'b0}};
      rr_ptr_r    <= {PW{1'b0}};
      gen_reset_r <= 1'b0;
      gen_seed_r  <= SEED_DEFAULT;
      gnt_r       <= {N_REQ{1'b0}};
      rand_r      <= {BITLENGTH{1'b0}};
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      warm_cnt_r  <= warm_cnt_s;
      rr_ptr_r    <= rr_ptr_s;
      gen_reset_r <= gen_reset_s;
      gen_seed_r  <= gen_seed_s;
      gnt_r       <= gnt_s;
      rand_r      <= rand_s;
      ready_r     <= ready_s;
    end
  end

  // Next-state logic; a reseed request overrides every state.
  always_comb begin
    state_s = state_r;
    if (bus.seed_load) begin
      state_s = ST_SEED;
    end else begin
      case (state_r)
        ST_SEED: state_s = ST_WARM;
        ST_WARM: begin
          if (warm_cnt_r == {CW{1'b0}}) begin
            state_s = ST_SERVE;
          end else begin
            state_s = ST_WARM;
          end
        end
        ST_SERVE: state_s = ST_SERVE;
        default:  state_s = ST_SEED;
      endcase
    end
  end

  // Next values of the registered outputs, warm-up counter and round-robin pointer.
  always_comb begin
    warm_cnt_s  = warm_cnt_r;
    rr_ptr_s    = rr_ptr_r;
    gen_reset_s = 1'b0;
    gen_seed_s  = gen_seed_r;
    gnt_s       = {N_REQ{1'b0}};
    rand_s      = rand_r;
    ready_s     = (state_s == ST_SERVE);
    if (bus.seed_load) begin
      gen_seed_s = bus.seed_in;
      rr_ptr_s   = {PW{1'b0}};
    end else begin
      case (state_r)
        ST_SEED: begin
          gen_reset_s = 1'b1;
          warm_cnt_s  = CW'(WARMUP - 1);
        end
        ST_WARM: begin
          if (warm_cnt_r != {CW{1'b0}}) begin
            warm_cnt_s = warm_cnt_r - CW'(1);
          end else begin
            warm_cnt_s = warm_cnt_r;
          end
        end
        ST_SERVE: begin
          if (pick_s[PW]) begin
            gnt_s  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s[PW-1:0];
            rand_s = bus.rng_data;
            if (pick_s[PW-1:0] == PW'(N_REQ - 1)) begin
              rr_ptr_s = {PW{1'b0}};
            end else begin
              rr_ptr_s = pick_s[PW-1:0] + PW'(1);
            end
          end else begin
            gnt_s = {N_REQ{1'b0}};
          end
        end
        default: begin
          gen_reset_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.gen_reset = gen_reset_r;
  assign bus.gen_seed  = gen_seed_r;
  assign bus.gnt       = gnt_r;
  assign bus.rand_out  = rand_r;
  assign bus.ready     = ready_r;

endmodule
